dircc_mem_msg_reader: RTL and testbench
=======================================

# dircc_mem_msg_reader

Avalon-MM read master that drains one message from a node's processing memory through its 16-bit second port (s2) and emits it as an Avalon-ST halfword stream with start/end-of-packet markers. It sits between the dual-port processing memory and the node's outbound message path. Software writes the message on the 32-bit port, then issues a descriptor here. The block is read-only: it never writes the memory.

## Interface
Parameters:
- ADDR_W, 15, halfword address width (matches s2)
- LEN_W, 8, descriptor length field width
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  descriptor offered
- cmd_ready  out  1  descriptor accepted when cmd_valid & cmd_ready
- cmd_addr  in  ADDR_W  first halfword address
- cmd_len  in  LEN_W  halfword count; 0 encodes 2^LEN_W
- mem_address  out  ADDR_W  to s2 address
- mem_chipselect  out  1  read strobe to s2
- mem_clken  out  1  s2 clock enable, tied 1
- mem_write  out  1  tied 0
- mem_byteenable  out  2  tied 2'b11
- mem_readdata  in  16  s2 read data
- out_valid  out  1  stream word valid
- out_ready  in  1  sink accepts word
- out_data  out  16  halfword
- out_sop / out_eop  out  1  first / last word of message
- busy  out  1  descriptor in progress
- done  out  1  one-cycle pulse on the cycle the eop word is accepted

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: cmd_ready=1. On accept, latch addr, remaining=cmd_len (0→2^LEN_W), set first flag, and go to READ.
- READ: issue one read per cycle (mem_chipselect=1) while credit > 0. Credit = FIFO_DEPTH − occupancy − in-flight reads. mem_address increments by 1 per issued read and wraps modulo 2^ADDR_W (0x7FFF→0x0000). After the last read is issued, go to DRAIN.
- Read data is valid exactly 1 cycle after the address is presented (registered address, unregistered output). It is written into the FIFO on that cycle, tagged with sop (first word) and eop (last word).
- DRAIN: no reads are issued. Return to IDLE on the cycle the eop word is accepted; done pulses that same cycle.
- out_valid = FIFO non-empty; out_data/out_sop/out_eop come from the FIFO head. Pop on out_valid & out_ready.
- busy = state ≠ IDLE.
- cmd_ready is 0 outside IDLE, so descriptors are never back-to-back within the same cycle as done.
- Credit accounting guarantees the FIFO never overflows; data returning while the FIFO is full is impossible by construction.

## Timing
- Reset values: cmd_ready=1, busy=0, done=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, mem_chipselect=0, mem_address=0; mem_clken=1, mem_write=0, mem_byteenable=2'b11 at all times.
- Latency: cmd accept at cycle 0; first read at cycle 1; out_valid at cycle 3 (FIFO registered).
- With out_ready held high, throughput is 1 word/cycle. A message of N words gives done at cycle N+2.
- Simultaneous FIFO push and pop at full or empty is legal; occupancy is unchanged.
- out_valid, once asserted, holds with stable data until accepted.
- reset_n asserted mid-message: everything returns to reset values immediately; the partial message is discarded with no eop emitted.

## Configuration
- DIRCC_MEM_READER_CSUM_EN defined: adds output csum[15:0], the running XOR of all halfwords of the current message. It is cleared on cmd accept and is valid (final) on the cycle done pulses.
- Not defined: no csum port and no checksum logic.

## Test plan
- cmd_addr=0x0010, cmd_len=4, memory 0x0010..0x0013 = A0A0,B1B1,C2C2,D3D3, out_ready=1 -> 4 words in order; sop on A0A0, eop on D3D3; done at cycle 6.
- cmd_len=1 -> a single word with sop=eop=1 and one done pulse.
- cmd_addr=0x7FFE, cmd_len=3 -> reads 0x7FFE, 0x7FFF, 0x0000.
- Same 4-word message with out_ready low for 10 cycles after the first word -> no lost or duplicated words; at most FIFO_DEPTH reads outstanding plus buffered; data stable while stalled.
- cmd_len=0 (LEN_W=8) -> 256 words; eop on the 256th.
- reset_n pulsed low after word 2 of an 8-word message -> outputs return to reset values at once; a new descriptor then completes correctly. With the CSUM macro defined, words 0x1234, 0x00FF give csum=0x12CB.

Source files
------------

// File: rtl/dircc_mem_msg_reader.sv
// -----------------------------------------------------------------------------
// dircc_mem_msg_reader
//
// Drains one message from a node's dual-port processing memory through its
// 16-bit second port (s2) and emits it as an Avalon-ST halfword stream framed
// with start/end-of-packet markers. The block is a read-only Avalon-MM master:
// it never writes the memory.
//
// A descriptor (cmd_addr, cmd_len) is accepted in IDLE. READ then issues one
// s2 read per cycle while output-buffer credit is available, and DRAIN waits
// for the last (eop) word to be accepted downstream.
//
// Ports
//   clk, reset_n        single clock, asynchronous active-low reset
//   cmd_valid/ready     descriptor handshake; cmd_addr = first halfword
//                       address, cmd_len = halfword count (0 means 2^LEN_W)
//   mem_*               s2 read master (address registered in the memory,
//                       read data valid exactly one cycle after the address)
//   out_valid/ready     halfword stream handshake; out_data/out_sop/out_eop
//   busy                descriptor in progress
//   done                one-cycle pulse on the cycle the eop word is accepted
//   dbg_state           current FSM state (IDLE=0, READ=1, DRAIN=2)
//   csum                running XOR of the message halfwords, only present
//                       when DIRCC_MEM_READER_CSUM_EN is defined
//
// Handshakes: a transfer happens on a cycle where valid && ready are both
// high. Once out_valid is raised it stays high with out_data/out_sop/out_eop
// stable until the word is accepted; the sink may toggle out_ready freely.
//
// Build option
//   DIRCC_MEM_READER_CSUM_EN  adds the csum output; cleared on descriptor
//                             accept, final on the cycle done pulses.
// -----------------------------------------------------------------------------
module dircc_mem_msg_reader #(
    parameter int ADDR_W     = 15,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [1:0]        mem_byteenable,
    input  logic [15:0]       mem_readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_sop,
    output logic              out_eop,
`ifdef DIRCC_MEM_READER_CSUM_EN
    output logic [15:0]       csum,
`endif
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W:0]    remaining_q, remaining_d;   // one extra bit holds 2^LEN_W
    logic              first_q, first_d;
    // Tags of the read issued last cycle; its data is on mem_readdata now.
    logic              rd_pend_q, rd_pend_d;
    logic              rd_sop_q, rd_sop_d;
    logic              rd_eop_q, rd_eop_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
`ifdef DIRCC_MEM_READER_CSUM_EN
    logic [15:0]       csum_q, csum_d;
`endif

    logic [15:0] fifo_data_q [FIFO_DEPTH];
    logic        fifo_sop_q  [FIFO_DEPTH];
    logic        fifo_eop_q  [FIFO_DEPTH];

    logic           push;
    logic           pop;
    logic           issue;
    logic           fifo_nonempty;
    logic [CNT_W:0] committed;

    // ------------------------------------------------------------------
    // Datapath / handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        fifo_nonempty = (count_q != '0);
        // Entries already buffered plus the read whose data is still
        // returning; a new read is only issued if it is guaranteed a slot,
        // so the FIFO can never be written while full.
        committed = {1'b0, count_q} + (CNT_W+1)'(rd_pend_q);
        issue     = (state_q == S_READ) && (committed < DEPTH_C);
        push      = rd_pend_q;
        pop       = fifo_nonempty && out_ready;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        rd_pend_d   = issue;
        rd_sop_d    = issue && first_q;
        rd_eop_d    = issue && (remaining_q == (LEN_W+1)'(1));
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        done        = 1'b0;
`ifdef DIRCC_MEM_READER_CSUM_EN
        csum_d      = push ? (csum_q ^ mem_readdata) : csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    remaining_d = (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}}
                                                  : {1'b0, cmd_len};
                    first_d     = 1'b1;
                    state_d     = S_READ;
`ifdef DIRCC_MEM_READER_CSUM_EN
                    csum_d      = 16'h0000;
`endif
                end
            end
            S_READ: begin
                if (issue) begin
                    // Address wraps naturally modulo 2^ADDR_W.
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (LEN_W+1)'(1);
                    first_d     = 1'b0;
                    if (remaining_q == (LEN_W+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && fifo_eop_q[rd_ptr_q]) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_sop_q    <= 1'b0;
            rd_eop_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
`ifdef DIRCC_MEM_READER_CSUM_EN
            csum_q      <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            rd_pend_q   <= rd_pend_d;
            rd_sop_q    <= rd_sop_d;
            rd_eop_q    <= rd_eop_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
`ifdef DIRCC_MEM_READER_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // Output buffer storage: returning read data is captured with its tags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= 16'h0000;
                fifo_sop_q[i]  <= 1'b0;
                fifo_eop_q[i]  <= 1'b0;
            end
        end else if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_readdata;
            fifo_sop_q[wr_ptr_q]  <= rd_sop_q;
            fifo_eop_q[wr_ptr_q]  <= rd_eop_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready      = (state_q == S_IDLE);
        busy           = (state_q != S_IDLE);
        dbg_state      = state_q;
        mem_address    = addr_q;
        mem_chipselect = issue;
        mem_clken      = 1'b1;
        mem_write      = 1'b0;
        mem_byteenable = 2'b11;
        out_valid      = fifo_nonempty;
        // Gated so the stream fields read zero whenever nothing is offered.
        out_data       = fifo_nonempty ? fifo_data_q[rd_ptr_q] : 16'h0000;
        out_sop        = fifo_nonempty && fifo_sop_q[rd_ptr_q];
        out_eop        = fifo_nonempty && fifo_eop_q[rd_ptr_q];
`ifdef DIRCC_MEM_READER_CSUM_EN
        csum           = csum_q;
`endif
    end

endmodule

// File: tb/tb_dircc_mem_msg_reader.sv
// -----------------------------------------------------------------------------
// tb_dircc_mem_msg_reader
//
// Bench for dircc_mem_msg_reader. A behavioural s2 memory (registered read,
// data one cycle after the address) is pre-loaded with a per-address pattern
// plus a few named words. Each message pushes its expected halfwords into
// exp_q and the stream output is checked word by word, together with sop/eop
// framing, issued read addresses, done timing and output-buffer credit.
// -----------------------------------------------------------------------------
module tb_dircc_mem_msg_reader;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [14:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [14:0] mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic        mem_write;
    logic [1:0]  mem_byteenable;
    logic [15:0] mem_readdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;
`ifdef DIRCC_MEM_READER_CSUM_EN
    logic [15:0] csum;
`endif

    dircc_mem_msg_reader #(
        .ADDR_W     (15),
        .LEN_W      (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
`ifdef DIRCC_MEM_READER_CSUM_EN
        .csum           (csum),
`endif
        .busy           (busy),
        .done           (done),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    logic [15:0] mem_model [0:32767];

    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem_model[mem_address];
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_sop"}, 32'(out_sop), 0);
        check({tag, "_out_eop"}, 32'(out_eop), 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
        check({tag, "_chipselect"}, 32'(mem_chipselect), 0);
        check({tag, "_address"}, 32'(mem_address), 0);
        check({tag, "_clken"}, 32'(mem_clken), 1);
        check({tag, "_write"}, 32'(mem_write), 0);
        check({tag, "_byteenable"}, 32'(mem_byteenable), 3);
    endtask

    // ---------------- driver / monitor ----------------
    // Runs one descriptor. stall_len>0 drops out_ready for stall_len cycles
    // after stall_after words are accepted. exp_done>=0 checks done cycle
    // and first out_valid cycle (3). abort_after>0 returns right after that
    // many words are accepted, leaving the message in flight.
    task automatic run_msg(input logic [14:0] a, input logic [7:0] l, input int n,
                           input int stall_after, input int stall_len,
                           input int exp_done, input int abort_after,
                           input logic check_csum);
        int issued;
        int popped;
        int stall_left;
        int max_out;
        int done_cyc;
        int first_valid;
        logic [15:0] exp_csum;
        logic [14:0] ea;
        logic [15:0] w;

        exp_q.delete();
        exp_csum = 16'h0000;
        for (int k = 0; k < n; k++) begin
            ea = a + 15'(k);
            exp_q.push_back(mem_model[ea]);
            exp_csum = exp_csum ^ mem_model[ea];
        end

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        out_ready = 1'b1;
        #1;
        check("cmd_ready_idle", 32'(cmd_ready), 1);

        issued = 0; popped = 0; stall_left = 0; max_out = 0;
        done_cyc = -1; first_valid = -1;

        for (int c = 1; c <= n + 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            out_ready = (stall_left == 0);
            #1;
            if (c == 1) begin
                check("busy_active", 32'(busy), 1);
                check("cmd_ready_busy", 32'(cmd_ready), 0);
            end
            if (mem_chipselect) begin
                ea = a + 15'(issued);
                check("rd_addr", 32'(mem_address), 32'(ea));
                issued++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (out_valid && first_valid < 0) first_valid = c;
            if (!out_ready && out_valid) begin
                if (exp_q.size() == 0) check("stall_extra_word", 0, 1);
                else                   check("stall_data", 32'(out_data), 32'(exp_q[0]));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    check("data", 32'(out_data), 32'(w));
                    check("sop", 32'(out_sop), 32'(popped == 0));
                    check("eop", 32'(out_eop), 32'(popped == n - 1));
                end
                popped++;
                if (stall_len > 0 && popped == stall_after) stall_left = stall_len + 1;
                if (abort_after > 0 && popped == abort_after) return;
            end
            if (stall_left > 0) stall_left--;
            if (done) begin
                done_cyc = c;
                check("done_with_last_word", 32'(popped), 32'(n));
`ifdef DIRCC_MEM_READER_CSUM_EN
                if (check_csum) check("csum", 32'(csum), 32'(exp_csum));
`endif
            end
        end

        if (done_cyc < 0) check("done_timeout", 0, 1);
        check("words_accepted", 32'(popped), 32'(n));
        check("reads_issued", 32'(issued), 32'(n));
        check("outstanding_le_depth", 32'(max_out <= 4), 1);
        if (exp_done >= 0) begin
            check("done_cycle", 32'(done_cyc), 32'(exp_done));
            check("first_valid_cycle", 32'(first_valid), 3);
        end

        @(negedge clk);
        #1;
        check("done_one_cycle", 32'(done), 0);
        check("idle_after_done", 32'(busy), 0);
        check("no_output_after_done", 32'(out_valid), 0);
        if (check_csum) begin end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [14:0] addr;
        logic [7:0]  len;
        int          n;
        int          exp_done;
    } vec_t;

    vec_t vecs[5];

    initial begin
        for (int i = 0; i < 32768; i++) mem_model[i] = 16'(i) ^ 16'hC3A5;
        mem_model[15'h0010] = 16'hA0A0;
        mem_model[15'h0011] = 16'hB1B1;
        mem_model[15'h0012] = 16'hC2C2;
        mem_model[15'h0013] = 16'hD3D3;
        mem_model[15'h0500] = 16'h1234;
        mem_model[15'h0501] = 16'h00FF;
        mem_readdata = 16'h0000;

        vecs[0] = '{addr: 15'h0010, len: 8'd4, n: 4,   exp_done: 6};
        vecs[1] = '{addr: 15'h0020, len: 8'd1, n: 1,   exp_done: 3};
        vecs[2] = '{addr: 15'h7FFE, len: 8'd3, n: 3,   exp_done: 5};
        vecs[3] = '{addr: 15'h0100, len: 8'd0, n: 256, exp_done: 258};
        vecs[4] = '{addr: 15'h0200, len: 8'd7, n: 7,   exp_done: 9};

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Hand-computed first/last words of the named message.
        check("model_word0", 32'(mem_model[15'h0010]), 32'h0000_A0A0);

        for (int v = 0; v < 5; v++) begin
            run_msg(vecs[v].addr, vecs[v].len, vecs[v].n, 0, 0, vecs[v].exp_done, 0, 1'b0);
        end

        // Back-pressure: sink stalls 10 cycles after the first word.
        run_msg(15'h0010, 8'd4, 4, 1, 10, -1, 0, 1'b0);

        // Reset in the middle of an 8-word message, then a clean message.
        run_msg(15'h0300, 8'd8, 8, 0, 0, -1, 2, 1'b0);
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        run_msg(15'h0400, 8'd5, 5, 0, 0, 7, 0, 1'b0);

        // Two-word message 0x1234, 0x00FF (checksum 0x12CB when enabled).
        run_msg(15'h0500, 8'd2, 2, 0, 0, 4, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
